// File: rtl/spi_ram_burst.sv
// spi_ram_burst: SPI slave that bridges burst reads and writes onto a single-port RAM.
// Ports: clk (system clock), rst (async, active-high), SS_n (active-low frame select),
//        MOSI (serial in, MSB first), MISO (registered serial out, MSB first),
//        frame_err (one-cycle pulse when a frame ends abnormally).
module spi_ram_burst #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int MEM_DEPTH  = 2**ADDR_WIDTH,
    parameter int AUTO_INC   = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic SS_n,
    input  logic MOSI,
    output logic MISO,
    output logic frame_err
);
    localparam int MAXW = ADDR_WIDTH > DATA_WIDTH ? ADDR_WIDTH : DATA_WIDTH;
    localparam int CW = $clog2(MAXW + 1);
    localparam int AW1 = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] C_DW = CW'(DATA_WIDTH);
    localparam logic [CW-1:0] C_AL = CW'(ADDR_WIDTH - 1);
    localparam logic [AW1-1:0] C_DEPTH = AW1'(MEM_DEPTH);
    localparam logic [AW1-1:0] C_LAST = AW1'(MEM_DEPTH - 1);

    typedef enum logic [2:0] {IDLE, CMD, ADDR, WDATA, RTURN, RDATA, DISCARD} state_t;

    state_t r_state;
    logic [CW-1:0] r_cnt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_sh;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic r_cmd_hi;
    logic r_rd;
    logic r_ss_prev;
    logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

    logic [ADDR_WIDTH-1:0] w_addr_in;
    logic [ADDR_WIDTH-1:0] w_addr_wrap;
    logic [ADDR_WIDTH-1:0] w_addr_next;
    logic w_we;
    logic w_load;
    logic w_abort_err;

    always_comb begin
        w_addr_in   = {r_addr[ADDR_WIDTH-2:0], MOSI};
        w_addr_wrap = ADDR_WIDTH'({1'b0, w_addr_in} % C_DEPTH);
        w_addr_next = (AUTO_INC == 0) ? r_addr : ({1'b0, r_addr} == C_LAST) ? '0 : r_addr + 1'b1;
        // A full word sits in r_sh one edge after its last bit was sampled.
        w_we        = (r_state == WDATA) && (r_cnt == C_DW);
        // Load the next read word on the second turnaround edge or after the last bit of a word.
        w_load      = ((r_state == RTURN) && (r_cnt != '0)) || ((r_state == RDATA) && (r_cnt == C_DW));
        w_abort_err = (r_state == CMD) || (r_state == ADDR) || (r_state == DISCARD) ||
                      ((r_state == WDATA) && (r_cnt != '0) && (r_cnt != C_DW));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_addr    <= '0;
            r_sh      <= '0;
            r_cmd_hi  <= 1'b0;
            r_rd      <= 1'b0;
            r_ss_prev <= 1'b0;
            MISO      <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            r_ss_prev <= SS_n;
            frame_err <= 1'b0;
            if (r_state != IDLE && SS_n) begin
                r_state   <= IDLE;
                r_cnt     <= '0;
                MISO      <= 1'b0;
                frame_err <= w_abort_err;
            end else begin
                case (r_state)
                    // A frame starts only on a seen high-to-low SS_n, so a reset mid-frame waits it out.
                    IDLE: if (!SS_n && r_ss_prev) begin
                        r_state <= CMD;
                        r_cnt   <= '0;
                        r_sh    <= '0;
                    end
                    CMD: if (r_cnt == '0) begin
                        r_cmd_hi <= MOSI;
                        r_cnt    <= CW'(1);
                    end else begin
                        r_cnt   <= '0;
                        r_rd    <= r_cmd_hi;
                        r_state <= MOSI ? DISCARD : ADDR;
                    end
                    ADDR: if (r_cnt == C_AL) begin
                        r_addr  <= w_addr_wrap;
                        r_cnt   <= '0;
                        r_state <= r_rd ? RTURN : WDATA;
                    end else begin
                        r_addr <= w_addr_in;
                        r_cnt  <= r_cnt + 1'b1;
                    end
                    WDATA: begin
                        r_sh <= {r_sh[DATA_WIDTH-2:0], MOSI};
                        if (w_we) begin
                            r_addr <= w_addr_next;
                            r_cnt  <= CW'(1);
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    // r_sh is cleared at frame start, so the first turnaround edge shifts out a 0.
                    RTURN, RDATA: if (w_load) begin
                        r_state <= RDATA;
                        r_addr  <= w_addr_next;
                        MISO    <= r_rdata[DATA_WIDTH-1];
                        r_sh    <= {r_rdata[DATA_WIDTH-2:0], 1'b0};
                        r_cnt   <= CW'(1);
                    end else begin
                        MISO  <= r_sh[DATA_WIDTH-1];
                        r_sh  <= {r_sh[DATA_WIDTH-2:0], 1'b0};
                        r_cnt <= r_cnt + 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Reading every cycle doubles as the prefetch: r_rdata tracks mem[r_addr] one edge late.
    always_ff @(posedge clk) begin
        if (w_we) r_mem[r_addr] <= r_sh;
        r_rdata <= r_mem[r_addr];
    end
endmodule

// File: tb/tb_spi_ram_burst.sv
// tb_spi_ram_burst: directed bench for spi_ram_burst in default and narrow-address configurations.
module tb_spi_ram_burst;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ss0 = 1'b1;
    logic mosi0 = 1'b0;
    logic miso0;
    logic err0;
    logic ss1 = 1'b1;
    logic mosi1 = 1'b0;
    logic miso1;
    logic err1;
    int n_vec = 0;
    int n_bad = 0;
    logic s_miso [0:255];
    int n_s;
    int errs;
    logic [9:0] rd_pre;

    always #5 clk = ~clk;

    spi_ram_burst u_d0 (
        .clk(clk), .rst(rst), .SS_n(ss0), .MOSI(mosi0), .MISO(miso0), .frame_err(err0)
    );

    spi_ram_burst #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .MEM_DEPTH(12), .AUTO_INC(0)) u_d1 (
        .clk(clk), .rst(rst), .SS_n(ss1), .MOSI(mosi1), .MISO(miso1), .frame_err(err1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic sample(input int sel);
        s_miso[n_s] = sel != 0 ? miso1 : miso0;
        errs += int'(sel != 0 ? err1 : err0);
        n_s++;
    endtask

    // Drives one frame: SS_n low, then n bits (plen-bit prefix, zero padded), then SS_n high.
    // s_miso[i] holds MISO in the cycle after edge E(i).
    task automatic frame(input int sel, input logic [63:0] pre, input int plen, input int n);
        logic b;
        n_s = 0;
        errs = 0;
        @(negedge clk);
        if (sel != 0) ss1 = 1'b0; else ss0 = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            sample(sel);
            b = i < plen ? pre[plen-1-i] : 1'b0;
            if (sel != 0) mosi1 = b; else mosi0 = b;
        end
        @(negedge clk);
        sample(sel);
        if (sel != 0) begin
            ss1 = 1'b1;
            mosi1 = 1'b0;
        end else begin
            ss0 = 1'b1;
            mosi0 = 1'b0;
        end
        repeat (3) begin
            @(negedge clk);
            sample(sel);
        end
    endtask

    function automatic logic [15:0] word_at(input int base, input int k, input int dw);
        logic [15:0] w = '0;
        for (int j = 0; j < dw; j++) w = {w[14:0], s_miso[base + k*dw + j]};
        return w;
    endfunction

    function automatic logic any_miso();
        logic a = 1'b0;
        for (int i = 0; i < n_s; i++) a = a | s_miso[i];
        return a;
    endfunction

    initial begin
        repeat (2) @(negedge clk);
        check("rst_miso0", miso0, 0);
        check("rst_err0", err0, 0);
        check("rst_miso1", miso1, 0);
        check("rst_err1", err1, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        frame(0, {2'b00, 8'h10, 8'hA5, 8'h3C, 8'hFF}, 34, 34);
        check("wr3_err", errs, 0);
        frame(0, {2'b10, 8'h10}, 10, 35);
        check("rd3_w0", word_at(12, 0, 8), 16'hA5);
        check("rd3_w1", word_at(12, 1, 8), 16'h3C);
        check("rd3_w2", word_at(12, 2, 8), 16'hFF);
        check("rd3_turn", {s_miso[10], s_miso[11]}, 0);
        check("rd3_end", s_miso[36], 0);
        check("rd3_err", errs, 0);

        frame(0, {2'b00, 8'hFF, 8'h11, 8'h22}, 26, 26);
        check("wrap_wr_err", errs, 0);
        frame(0, {2'b10, 8'hFF}, 10, 27);
        check("wrap_rd_w0", word_at(12, 0, 8), 16'h11);
        check("wrap_rd_w1", word_at(12, 1, 8), 16'h22);

        frame(0, {2'b00, 8'h20, 8'h00, 8'h77}, 26, 26);
        frame(0, {2'b00, 8'h20, 8'h55, 3'b101}, 21, 21);
        check("abort_wd_err", errs, 1);
        frame(0, {2'b10, 8'h20}, 10, 27);
        check("abort_rd_20", word_at(12, 0, 8), 16'h55);
        check("abort_rd_21", word_at(12, 1, 8), 16'h77);
        frame(0, {2'b00, 4'h2}, 6, 6);
        check("abort_addr_err", errs, 1);

        frame(0, {2'b01, 20'hFFFFF}, 22, 22);
        check("rsvd_err", errs, 1);
        check("rsvd_miso", any_miso(), 0);
        frame(0, {2'b10, 8'h10}, 10, 19);
        check("rsvd_rd_10", word_at(12, 0, 8), 16'hA5);

        rd_pre = {2'b10, 8'h10};
        @(negedge clk);
        ss0 = 1'b0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            mosi0 = i < 10 ? rd_pre[9-i] : 1'b0;
        end
        @(negedge clk);
        check("mid_rd_miso", miso0, 1);
        #2 rst = 1'b1;
        #1 check("rst_async_miso", miso0, 0);
        check("rst_async_err", err0, 0);
        @(negedge clk);
        rst = 1'b0;
        errs = 0;
        repeat (4) begin
            @(negedge clk);
            errs += int'(err0);
        end
        check("post_rst_miso", miso0, 0);
        check("post_rst_err", errs, 0);
        ss0 = 1'b1;
        mosi0 = 1'b0;
        repeat (2) @(negedge clk);
        frame(0, {2'b10, 8'h11}, 10, 19);
        check("post_rst_rd_11", word_at(12, 0, 8), 16'h3C);
        check("post_rst_rd_err", errs, 0);

        frame(1, {2'b00, 4'd11, 16'h1234, 16'hBEEF}, 38, 38);
        check("p1_wr_err", errs, 0);
        frame(1, {2'b10, 4'd11}, 6, 39);
        check("p1_rd_w0", word_at(8, 0, 16), 16'hBEEF);
        check("p1_rd_w1", word_at(8, 1, 16), 16'hBEEF);
        frame(1, {2'b00, 4'd13, 16'hCAFE}, 22, 22);
        frame(1, {2'b10, 4'd1}, 6, 23);
        check("p1_wrap_rd_1", word_at(8, 0, 16), 16'hCAFE);
        frame(1, {2'b10, 4'd11}, 6, 23);
        check("p1_rd_11_kept", word_at(8, 0, 16), 16'hBEEF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
